// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Purpose: sequences resolution of one conditional branch at a time.  A
//   decoded branch is accepted, its compare is issued to the shared ALU, the
//   ALU result is awaited, and the branch is then resolved against the fetch
//   prediction.  On a mispredict the corrected fetch PC is published together
//   with a flush of the younger stages.
//
// Optional feature: define BRANCH_STATS_EN to add two saturating 16-bit
//   event counters (resolved branches, mispredicts) and their output ports.
//
// Ports:
//   clk, reset          sole rising-edge clock, synchronous active-high reset
//   br_valid/br_ready   decode branch request handshake
//   br_funct3, br_pc, br_offset, br_pred_taken   branch descriptor
//   alu_req, alu_funct3 compare issue pulse and its funct3
//   alu_rsp_valid, alu_zero   ALU response (result equal zero)
//   kill                exception abort, returns the block to IDLE
//   redirect_valid, redirect_pc, flush   mispredict correction
//   illegal_br          pulse for reserved funct3 010/011
//   done                pulse on every resolution
//   stat_branches, stat_mispredicts   (BRANCH_STATS_EN only) counters
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            br_valid,
   output logic            br_ready,
   input  logic [2:0]      br_funct3,
   input  logic [XLEN-1:0] br_pc,
   input  logic [XLEN-1:0] br_offset,
   input  logic            br_pred_taken,
   output logic            alu_req,
   output logic [2:0]      alu_funct3,
   input  logic            alu_rsp_valid,
   input  logic            alu_zero,
   input  logic            kill,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            illegal_br,
   output logic            done
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]     stat_branches,
   output logic [15:0]     stat_mispredicts
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESOLVE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t          state_q, state_d;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] offset_q;
   logic            pred_q;
   logic            zero_q;
   logic [XLEN-1:0] redirect_pc_q;

   logic            active;
   logic            is_illegal;
   logic            taken;
   logic            mispredict;
   logic [XLEN-1:0] target;

   // Pulses are suppressed while reset or kill is high; reset also wins in
   // the state register below.
   assign active = !reset && !kill;

   // Even funct3 (EQ/LT/LTU) branch when the compare result is non-zero,
   // odd funct3 (NE/GE/GEU) when it is zero.  Reserved encodings never branch.
   assign is_illegal = (funct3_q[2:1] == 2'b01);
   assign taken      = !is_illegal && (funct3_q[0] ? zero_q : !zero_q);
   assign mispredict = !is_illegal && (taken != pred_q);
   assign target     = taken ? (pc_q + offset_q) : (pc_q + PC_STEP);

   assign alu_funct3 = funct3_q;

   // The corrected PC is visible in the same cycle as redirect_valid and is
   // held afterwards, so downstream logic may sample it late.
   assign redirect_pc = redirect_valid ? target : redirect_pc_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      br_ready       = 1'b0;
      alu_req        = 1'b0;
      redirect_valid = 1'b0;
      flush          = 1'b0;
      illegal_br     = 1'b0;
      done           = 1'b0;
      unique case (state_q)
         IDLE: begin
            br_ready = active;
            if (active && br_valid) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            alu_req = active;
            state_d = WAIT;
         end
         WAIT: begin
            if (alu_rsp_valid) begin
               state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            done           = active;
            illegal_br     = active && is_illegal;
            redirect_valid = active && mispredict;
            flush          = active && mispredict;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (kill) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         funct3_q      <= 3'd0;
         pc_q          <= '0;
         offset_q      <= '0;
         pred_q        <= 1'b0;
         zero_q        <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         if (br_valid && br_ready) begin
            funct3_q <= br_funct3;
            pc_q     <= br_pc;
            offset_q <= br_offset;
            pred_q   <= br_pred_taken;
         end
         if ((state_q == WAIT) && alu_rsp_valid && !kill) begin
            zero_q <= alu_zero;
         end
         if (redirect_valid) begin
            redirect_pc_q <= target;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches    <= 16'd0;
         stat_mispredicts <= 16'd0;
      end else begin
         if (done) begin
            stat_branches <= sat_inc(stat_branches);
         end
         if (redirect_valid) begin
            stat_mispredicts <= sat_inc(stat_mispredicts);
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Purpose: self-checking bench for branch_resolve_ctrl.  Each branch is
//   scripted at transaction level (accept, issue, wait, resolve); the expected
//   outcome comes from the branch rules evaluated with plain arithmetic.  A
//   single negedge process compares every output on every checked cycle.
//   Define BRANCH_STATS_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            br_valid;
   logic            br_ready;
   logic [2:0]      br_funct3;
   logic [XLEN-1:0] br_pc;
   logic [XLEN-1:0] br_offset;
   logic            br_pred_taken;
   logic            alu_req;
   logic [2:0]      alu_funct3;
   logic            alu_rsp_valid;
   logic            alu_zero;
   logic            kill;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            flush;
   logic            illegal_br;
   logic            done;
`ifdef BRANCH_STATS_EN
   logic [15:0]     stat_branches;
   logic [15:0]     stat_mispredicts;
`endif

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.XLEN(XLEN)) dut (
      .clk            (clk),
      .reset          (reset),
      .br_valid       (br_valid),
      .br_ready       (br_ready),
      .br_funct3      (br_funct3),
      .br_pc          (br_pc),
      .br_offset      (br_offset),
      .br_pred_taken  (br_pred_taken),
      .alu_req        (alu_req),
      .alu_funct3     (alu_funct3),
      .alu_rsp_valid  (alu_rsp_valid),
      .alu_zero       (alu_zero),
      .kill           (kill),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .illegal_br     (illegal_br),
      .done           (done)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Expected outputs for the current cycle.
   bit              e_ready, e_req, e_redir, e_flush, e_ill, e_done;
   logic [2:0]      e_f3;
   logic [XLEN-1:0] m_rpc;
   int              m_br, m_mis;

   task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check1("br_ready", br_ready, e_ready);
         check1("alu_req", alu_req, e_req);
         if (e_req) check1("alu_funct3", alu_funct3, e_f3);
         check1("redirect_valid", redirect_valid, e_redir);
         check1("flush", flush, e_flush);
         check1("illegal_br", illegal_br, e_ill);
         check1("done", done, e_done);
         check1("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
         check1("stat_branches", stat_branches, sat16(m_br));
         check1("stat_mispredicts", stat_mispredicts, sat16(m_mis));
`endif
      end
   end

   // Advance one cycle: account for events of the cycle just ended, then
   // clear expectations and scramble data inputs that must not matter.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (e_done) m_br++;
      if (e_redir) m_mis++;
      e_ready = 0; e_req = 0; e_redir = 0; e_flush = 0; e_ill = 0; e_done = 0;
      br_valid = 0; alu_rsp_valid = 0; kill = 0;
      br_funct3 = 3'($urandom); br_pc = $urandom; br_offset = $urandom;
      br_pred_taken = 1'($urandom); alu_zero = 1'($urandom);
   endtask

   task automatic idle_cycle(input bit kill_req);
      cyc();
      alu_rsp_valid = 1'($urandom);
      if (kill_req) begin
         br_valid = 1;
         kill     = 1;
         e_ready  = 0;
      end else begin
         e_ready = 1;
      end
   endtask

   // km: 0 normal, 1 kill in ISSUE, 2 kill in WAIT, 3 kill in RESOLVE,
   //     4 reset in WAIT
   task automatic branch(input logic [2:0] f3, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] off, input bit pred, input bit zero,
                         input int dly, input int km);
      bit ill, tk, mis;
      cyc();
      br_valid = 1; br_funct3 = f3; br_pc = pc; br_offset = off; br_pred_taken = pred;
      e_ready = 1;
      cyc();
      br_valid = 1'($urandom); alu_rsp_valid = 1'($urandom);
      e_f3 = f3;
      if (km == 1) begin
         kill = 1;
         return;
      end
      e_req = 1;
      for (int i = 0; i < dly; i++) begin
         cyc();
         br_valid = 1'($urandom);
      end
      if (km == 2) begin
         cyc();
         kill = 1; br_valid = 1'($urandom); alu_rsp_valid = 1'($urandom);
         return;
      end
      if (km == 4) begin
         cyc();
         reset = 1; br_valid = 1'($urandom); alu_rsp_valid = 1'($urandom);
         cyc();
         reset = 0; m_rpc = '0; m_br = 0; m_mis = 0; e_ready = 1;
         return;
      end
      cyc();
      alu_rsp_valid = 1; alu_zero = zero; br_valid = 1'($urandom);
      cyc();
      alu_rsp_valid = 1'($urandom); br_valid = 1'($urandom);
      if (km == 3) begin
         kill = 1;
         return;
      end
      ill = (f3 == 3'b010) || (f3 == 3'b011);
      tk  = !ill && (f3[0] ? zero : !zero);
      mis = !ill && (tk != pred);
      e_done = 1; e_ill = ill; e_redir = mis; e_flush = mis;
      if (mis) m_rpc = tk ? pc + off : pc + 32'd4;
   endtask

   task automatic pin_rpc(input string name, input logic [XLEN-1:0] want);
      idle_cycle(0);
      @(negedge clk);
      check1(name, redirect_pc, want);
   endtask

   initial begin
      reset = 1; br_valid = 0; br_funct3 = 0; br_pc = 0; br_offset = 0;
      br_pred_taken = 0; alu_rsp_valid = 0; alu_zero = 0; kill = 0;
      m_rpc = '0; m_br = 0; m_mis = 0; e_f3 = 0;
      e_ready = 0; e_req = 0; e_redir = 0; e_flush = 0; e_ill = 0; e_done = 0;
      repeat (3) @(posedge clk);
      cyc();
      reset = 0; e_ready = 1; chk_en = 1;

      // BEQ taken mispredict
      branch(3'b000, 32'h100, 32'h20, 0, 0, 0, 0);
      pin_rpc("pin_beq_target", 32'h120);
      // BNE not-taken mispredict, then correctly predicted BNE
      branch(3'b001, 32'h200, 32'h40, 1, 0, 1, 0);
      pin_rpc("pin_bne_fallthrough", 32'h204);
      branch(3'b001, 32'h300, 32'h40, 1, 1, 2, 0);
      pin_rpc("pin_bne_hold", 32'h204);
      // reserved funct3
      branch(3'b010, 32'h400, 32'h80, 1, 0, 0, 0);
      pin_rpc("pin_illegal_hold", 32'h204);
      // wrap-around target
      branch(3'b000, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0);
      pin_rpc("pin_wrap", 32'h10);
      // kill in WAIT followed by a late response, then a fresh branch
      branch(3'b100, 32'h500, 32'h10, 0, 0, 1, 2);
      cyc();
      alu_rsp_valid = 1; e_ready = 1;
      branch(3'b101, 32'h600, 32'h30, 0, 1, 0, 0);
      pin_rpc("pin_after_kill", 32'h630);
      // kill while br_valid in IDLE must not accept
      idle_cycle(1);
      idle_cycle(0);
      // reset in WAIT, then a fresh branch
      branch(3'b110, 32'h700, 32'h10, 0, 0, 0, 4);
      pin_rpc("pin_after_reset", 32'h0);
      branch(3'b111, 32'h800, 32'h8, 1, 0, 0, 0);
      pin_rpc("pin_geu_fallthrough", 32'h804);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         int r, km;
         r = int'($urandom_range(0, 7));
         km = (r < 4) ? 0 : r - 3;
         repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 3) == 0);
         branch(3'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), km);
      end

`ifdef BRANCH_STATS_EN
      for (int n = 0; n < 70000; n++) begin
         branch(3'b000, 32'h1000, 32'h40, 0, 0, 0, 0);
      end
      idle_cycle(0);
      @(negedge clk);
      check1("stat_branches_sat", stat_branches, 16'hFFFF);
      check1("stat_mispredicts_sat", stat_mispredicts, 16'hFFFF);
`endif

      idle_cycle(0);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
